seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, the next generation of the team's fixed 3-bit "101" Mealy detector. It matches a runtime-loadable W-bit pattern on a qualified serial bit stream, with selectable overlapping or non-overlapping detection. It produces a same-cycle Mealy match pulse, a registered copy of that pulse, and a saturating match counter. It sits between a serial bit source and status/interrupt logic.

## Interface
- W, default 3: pattern length in bits, legal range 2..16.
- PAT_INIT, default 3'b101 (W bits): pattern in force after reset.
- CNT_W, default 8: width of the match counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  1  serial data bit.
- valid  in  1  qualifies x; a bit is consumed only on an edge where valid=1.
- load  in  1  pattern/mode load strobe.
- pat  in  W  new pattern, sampled when load=1; pat[W-1] is the first bit received, pat[0] the last.
- overlap  in  1  new mode, sampled when load=1; 1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  clears match_cnt.
- y  out  1  Mealy match: combinational, high in the cycle whose valid bit completes the pattern.
- y_q  out  1  y registered; high for one cycle, one cycle after y.
- match_cnt  out  CNT_W  number of matches, saturating.

## Operation
- State: pat_r (W), ovl_r (1), hist (W-1 bits: most recent consumed bits, hist[0] newest), fill (0..W-1: consumed bits since last restart, saturates at W-1), y_q, match_cnt.
- Match condition: y = valid & ~reset & ~load & (fill == W-1) & ({hist, x} == pat_r).
- Priority on each edge: reset > load > bit consumption.
- reset=1: pat_r<=PAT_INIT, ovl_r<=1, hist<=0, fill<=0, y_q<=0, match_cnt<=0. y=0 while reset is high.
- load=1 (no reset): pat_r<=pat, ovl_r<=overlap, hist<=0, fill<=0. The x/valid input in that cycle is discarded, y=0, and match_cnt is unaffected except by cnt_clr.
- Valid bit consumed, no match: hist<={hist[W-3:0], x}, fill<=min(fill+1, W-1).
- Valid bit consumed, match, ovl_r=1: same shift/fill update as no match, so the suffix of a match may start the next one.
- Valid bit consumed, match, ovl_r=0: hist<=0, fill<=0. The next match needs W fresh bits.
- valid=0: hist, fill and pat_r hold. Gaps of any length are transparent.
- match_cnt: on an edge with y=1, it increments unless already all-ones, where it holds. When cnt_clr=1, match_cnt<=0; clear wins over a simultaneous match. reset also clears it.
- y_q<=y every edge (0 under reset).
- With defaults (W=3, PAT_INIT=101, overlap) and valid tied high, y is cycle-identical to the previous-generation detector.

## Timing
- y: zero latency, combinational from x/valid/load/reset and registered state. Consumers must sample it at the same edge that consumes the bit.
- y_q and match_cnt reflect a match one edge after the completing bit.
- A new pattern is effective for the first valid bit after the load edge. Detection needs W valid bits after load or reset.
- Reset mid-pattern discards partial history. The first match afterwards requires W new valid bits and uses PAT_INIT, even if a different pattern had been loaded.
- No back-pressure. Every valid bit is consumed in its cycle.

## Test plan
- Reset defaults, valid=1, x = 1,0,1,0,1 -> y high on bits 3 and 5 only; y_q high one cycle later each; match_cnt=2.
- load pat=101 overlap=0, then x = 1,0,1,0,1,0,1 -> y on bits 3 and 7 only; match_cnt=2. Repeat with overlap=1 -> y on bits 3, 5, 7.
- Valid gaps: x=1, then valid=0 for 4 cycles with x toggling, then x=0, x=1 -> single y on the final bit; no y during the gap.
- W=4, load pat=1111: six consecutive 1s -> y on bits 4, 5, 6 in overlap mode; only bit 4 in non-overlap mode.
- CNT_W=2: five matches -> match_cnt sequence 1, 2, 3, 3, 3. cnt_clr asserted on a matching edge -> match_cnt=0 next cycle, y still pulses.
- load pat=110, feed 1,1, assert reset for one edge, then feed 0,1 -> no y; then feed 0,1 -> y on that final bit (PAT_INIT=101 restored, history 1,0,1).

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-loadable W-bit serial pattern detector with overlapping or
// non-overlapping matching, a Mealy match pulse, its registered copy and a saturating counter.
module seq_detect_param #(
    parameter int              W        = 3,
    parameter logic [W-1:0]    PAT_INIT = W'(3'b101),
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             load,
    input  logic [W-1:0]     pat,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int            FILL_W = $clog2(W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W - 1);

    logic [W-1:0]     pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [W-2:0]     hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic             y_reg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]     shift_w;
    logic             hit;

    // Stream handshake: valid qualifies x, there is no ready; every valid bit is consumed on its edge.
    assign shift_w = {hist_q, x};
    assign hit     = (fill_q == FILL_FULL) && (shift_w == pat_q);
    assign y       = valid & ~reset & ~load & hit;

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            pat_d  = pat;
            ovl_d  = overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            if (y && !ovl_q) begin
                // Non-overlapping: a match restarts the search from scratch.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = shift_w[W-2:0];
                fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (y && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_INIT;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            y_reg_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_reg_q <= y;
            cnt_q   <= cnt_d;
        end
    end

    assign y_q       = y_reg_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: vector tables for the directed corner cases on three
// parameterisations, then random traffic against a queue-based reference model.
module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       x;
    logic       valid;
    logic       load;
    logic [3:0] pat_v;
    logic       overlap;
    logic       cnt_clr;

    logic       y_a, yq_a, y_b, yq_b, y_c, yq_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       vld;
        logic       xb;
        logic       ovl;
        logic       clr;
        logic [3:0] pat;
        logic       ey;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    // Default instance: W=3, pattern 101, 8-bit counter.
    seq_detect_param dut_a (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .load(load),
        .pat(pat_v[2:0]), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y_a), .y_q(yq_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.W(4), .PAT_INIT(4'b0101), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .load(load),
        .pat(pat_v), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y_b), .y_q(yq_b), .match_cnt(cnt_b)
    );

    seq_detect_param #(.W(3), .PAT_INIT(3'b101), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .load(load),
        .pat(pat_v[2:0]), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y_c), .y_q(yq_c), .match_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic ld, input logic vld,
                                input logic xb, input logic [3:0] pat, input logic ovl,
                                input logic clr, input logic ey, input logic [7:0] ecnt);
        vec_t v;
        v.rst = rst; v.ld = ld; v.vld = vld; v.xb = xb; v.pat = pat;
        v.ovl = ovl; v.clr = clr; v.ey = ey; v.ecnt = ecnt;
        return v;
    endfunction

    // Plain valid bit: no reset, no load, no clear.
    function automatic vec_t bitv(input logic xb, input logic ey, input logic [7:0] ecnt);
        return mk(1'b0, 1'b0, 1'b1, xb, 4'h0, 1'b0, 1'b0, ey, ecnt);
    endfunction

    task automatic check(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    task automatic apply_vec(input int sel, input vec_t v, input string nm, input int idx);
        logic       y_s, yq_s;
        logic [7:0] cnt_s;
        @(negedge clk);
        reset   = v.rst;
        load    = v.ld;
        valid   = v.vld;
        x       = v.xb;
        pat_v   = v.pat;
        overlap = v.ovl;
        cnt_clr = v.clr;
        #1;
        y_s = (sel == 0) ? y_a : (sel == 1) ? y_b : y_c;
        check({nm, "_y"}, idx, {7'd0, y_s}, {7'd0, v.ey});
        @(posedge clk);
        #1;
        yq_s  = (sel == 0) ? yq_a : (sel == 1) ? yq_b : yq_c;
        cnt_s = (sel == 0) ? cnt_a : (sel == 1) ? cnt_b : {6'd0, cnt_c};
        check({nm, "_yq"}, idx, {7'd0, yq_s}, {7'd0, v.ey});
        check({nm, "_cnt"}, idx, cnt_s, v.ecnt);
    endtask

    task automatic run_table(input int sel, input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(sel, tbl[i], nm, i);
        end
        tbl.delete();
    endtask

    // Reference model: the consumed bits since the last restart kept as a queue.
    bit       m_hq[$];
    bit [2:0] m_pat;
    bit       m_ovl;
    int       m_cnt;

    function automatic bit model_y(input vec_t v);
        int n;
        if (v.rst || v.ld || !v.vld) return 1'b0;
        n = m_hq.size();
        if (n < 2) return 1'b0;
        return (m_hq[n-2] == m_pat[2]) && (m_hq[n-1] == m_pat[1]) && (v.xb == m_pat[0]);
    endfunction

    task automatic model_step(input vec_t v, input bit yv);
        if (v.rst) begin
            m_pat = 3'b101;
            m_ovl = 1'b1;
            m_hq.delete();
            m_cnt = 0;
        end else begin
            if (v.ld) begin
                m_pat = v.pat[2:0];
                m_ovl = v.ovl;
                m_hq.delete();
            end else if (v.vld) begin
                if (yv && !m_ovl) begin
                    m_hq.delete();
                end else begin
                    m_hq.push_back(v.xb);
                    if (m_hq.size() > 8) void'(m_hq.pop_front());
                end
            end
            if (v.clr) m_cnt = 0;
            else if (yv && m_cnt < 255) m_cnt++;
        end
    endtask

    initial begin
        vec_t v;
        bit   yv;
        total = 0;
        bad = 0;
        reset = 1'b1; load = 1'b0; valid = 1'b0; x = 1'b0;
        pat_v = 4'h0; overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Defaults, overlapping 10101; then load non-overlap / overlap with a bit discarded on load.
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0101, 0, 0, 0, 8'd2));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 1, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1));
        tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(bitv(0, 0, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0101, 1, 1, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(bitv(0, 0, 2));
        tbl.push_back(bitv(1, 1, 3));
        // Valid gap with x toggling is transparent.
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        // Reset mid-pattern restores PAT_INIT and discards history.
        tbl.push_back(mk(0, 1, 0, 0, 4'b0110, 1, 0, 0, 8'd1));
        tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        run_table(0, "w3");

        // W=4, pattern 1111: overlap then non-overlap.
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 1, 0, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(bitv(1, 1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 1, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(bitv(1, 0, 1));
        run_table(1, "w4");

        // CNT_W=2 saturation, then clear winning over a simultaneous match.
        tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0));
        tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(bitv(0, 0, 2));
        tbl.push_back(bitv(1, 1, 3));
        tbl.push_back(bitv(0, 0, 3));
        tbl.push_back(bitv(1, 1, 3));
        tbl.push_back(bitv(0, 0, 3));
        tbl.push_back(bitv(1, 1, 3));
        tbl.push_back(bitv(0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 1, 4'h0, 0, 1, 1, 8'd0));
        tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 1, 1));
        run_table(2, "cnt2");

        // Random traffic on the default instance against the reference model.
        v = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 8'd0);
        model_step(v, 1'b0);
        apply_vec(0, v, "rnd", 0);
        for (int i = 1; i < 400; i++) begin
            v.rst = ($urandom_range(0, 79) == 0);
            v.ld  = ($urandom_range(0, 29) == 0);
            v.vld = ($urandom_range(0, 3) != 0);
            v.xb  = 1'($urandom_range(0, 1));
            v.pat = 4'($urandom_range(0, 7));
            v.ovl = 1'($urandom_range(0, 1));
            v.clr = ($urandom_range(0, 39) == 0);
            yv = model_y(v);
            v.ey = yv;
            model_step(v, yv);
            v.ecnt = 8'(m_cnt);
            apply_vec(0, v, "rnd", i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
